// File: rtl/if_fetch.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch
// Brief    : Instruction-fetch stage with boot delay, one-word stall hold
//            buffer and branch/jump redirect into the IF/ID register.
// Revision : 1.0 - initial release
// ============================================================================
module if_fetch #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned BOOT_CYCLES = 1
) (
  input  logic        reloj,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [25:0] jump_addr,
  input  logic [31:0] id_pc4,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_data,
  output logic [31:0] PC_4,
  output logic [31:0] DO,
  output logic        enableIF,
  output logic        resetIF,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  localparam logic [3:0] C_BOOT_LAST = 4'(BOOT_CYCLES - 1);

  state_t      r_state;
  logic [31:0] r_pc;
  logic [3:0]  r_boot_cnt;
  logic [31:0] r_hold_pc4;
  logic [31:0] r_hold_data;
  logic [31:0] r_fetch_count;

  logic        w_in_boot;
  logic        w_br;
  logic        w_jmp;
  logic        w_redirect;
  logic [31:0] w_target;
  logic [31:0] w_pc4;
  logic        w_unused;

  // Only the region bits of the ID-stage PC+4 feed the jump target.
  assign w_unused = &{1'b0, id_pc4[27:0]};

  assign w_pc4      = r_pc + 32'd4;
  assign w_in_boot  = (r_state == S_BOOT);
  assign w_br       = branch_taken & ~w_in_boot;
  assign w_jmp      = jump & ~stall & ~branch_taken & ~w_in_boot;
  assign w_redirect = w_br | w_jmp;
  assign w_target   = w_br ? branch_target : {id_pc4[31:28], jump_addr, 2'b00};

  assign imem_addr   = r_pc;
  assign imem_req    = (r_state == S_FETCH);
  assign resetIF     = reset | w_redirect;
  assign fetch_count = r_fetch_count;

  always_comb begin
    enableIF = 1'b0;
    PC_4     = 32'h0;
    DO       = 32'h0;
    case (r_state)
      S_FETCH: begin
        enableIF = imem_ready & ~stall & ~w_redirect;
        PC_4     = w_pc4;
        DO       = imem_data;
      end
      S_HOLD: begin
        enableIF = ~stall & ~w_redirect;
        PC_4     = r_hold_pc4;
        DO       = r_hold_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge reloj or posedge reset) begin
    if (reset) begin
      r_state       <= S_BOOT;
      r_pc          <= RESET_PC;
      r_boot_cnt    <= 4'd0;
      r_hold_pc4    <= 32'h0;
      r_hold_data   <= 32'h0;
      r_fetch_count <= 32'h0;
    end else begin
      if (enableIF)
        r_fetch_count <= r_fetch_count + 32'd1;
      case (r_state)
        S_BOOT: begin
          if (r_boot_cnt == C_BOOT_LAST)
            r_state <= S_FETCH;
          else
            r_boot_cnt <= r_boot_cnt + 4'd1;
        end
        S_FETCH: begin
          if (w_redirect) begin
            r_pc <= w_target;
          end else if (imem_ready) begin
            if (stall) begin
              r_hold_pc4  <= w_pc4;
              r_hold_data <= imem_data;
              r_state     <= S_HOLD;
            end else begin
              r_pc <= w_pc4;
            end
          end
        end
        S_HOLD: begin
          // PC still points at the held word, so PC+4 is the next fetch.
          if (w_redirect) begin
            r_pc    <= w_target;
            r_state <= S_FETCH;
          end else if (!stall) begin
            r_pc    <= w_pc4;
            r_state <= S_FETCH;
          end
        end
        default: r_state <= S_BOOT;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_if_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_fetch
// Brief    : Randomized and directed self-checking bench for if_fetch.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_fetch;

  localparam logic [31:0] C_RESET_PC = 32'h0000_0000;
  localparam int          C_BOOT     = 2;

  logic        reloj = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        jump = 1'b0;
  logic [25:0] jump_addr = 26'h0;
  logic [31:0] id_pc4 = 32'h0;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_data = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] PC_4;
  logic [31:0] DO;
  logic        enableIF;
  logic        resetIF;
  logic [31:0] fetch_count;

  if_fetch #(.RESET_PC(C_RESET_PC), .BOOT_CYCLES(C_BOOT)) dut (
    .reloj(reloj), .reset(reset), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_addr(jump_addr), .id_pc4(id_pc4),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_data(imem_data),
    .PC_4(PC_4), .DO(DO), .enableIF(enableIF), .resetIF(resetIF),
    .fetch_count(fetch_count)
  );

  always #5 reloj = ~reloj;

  int n_vec = 0;
  int n_err = 0;

  // Reference: a fetch pipeline holding at most one undelivered word.
  int          m_boot_left;
  logic [31:0] m_pc;
  logic [31:0] m_cnt;
  bit          m_held;
  logic [31:0] m_held_word;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h want %h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_init();
    m_boot_left = C_BOOT;
    m_pc        = C_RESET_PC;
    m_cnt       = 32'h0;
    m_held      = 1'b0;
    m_held_word = 32'h0;
  endtask

  // Called just after a falling edge; asserts reset mid-cycle.
  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    chk("rst_req", {31'h0, imem_req}, 32'h0);
    chk("rst_en", {31'h0, enableIF}, 32'h0);
    chk("rst_rif", {31'h0, resetIF}, 32'h1);
    chk("rst_addr", imem_addr, C_RESET_PC);
    chk("rst_cnt", fetch_count, 32'h0);
    chk("rst_do", DO, 32'h0);
    @(negedge reloj);
    reset = 1'b0;
    model_init();
  endtask

  task automatic set_in(input bit st, input bit rdy, input bit br, input logic [31:0] bt,
                        input bit j, input logic [25:0] ja, input logic [31:0] idp);
    stall = st; imem_ready = rdy; branch_taken = br; branch_target = bt;
    jump = j; jump_addr = ja; id_pc4 = idp; imem_data = $urandom;
  endtask

  // Checks the current cycle against the model, then advances one clock.
  task automatic step();
    logic        redir;
    logic [31:0] tgt;
    logic        have;
    logic [31:0] word;
    logic        deliver;
    #1;
    if (m_boot_left > 0) begin
      chk("boot_req", {31'h0, imem_req}, 32'h0);
      chk("boot_en", {31'h0, enableIF}, 32'h0);
      chk("boot_rif", {31'h0, resetIF}, 32'h0);
      chk("boot_pc4", PC_4, 32'h0);
      chk("boot_do", DO, 32'h0);
      chk("boot_addr", imem_addr, m_pc);
      m_boot_left--;
    end else begin
      redir = branch_taken || (jump && !stall);
      tgt   = branch_taken ? branch_target : {id_pc4[31:28], jump_addr, 2'b00};
      have  = m_held || imem_ready;
      word  = m_held ? m_held_word : imem_data;
      deliver = !redir && have && !stall;
      chk("addr", imem_addr, m_pc);
      chk("req", {31'h0, imem_req}, {31'h0, !m_held});
      chk("en", {31'h0, enableIF}, {31'h0, deliver});
      chk("rif", {31'h0, resetIF}, {31'h0, redir});
      chk("cnt", fetch_count, m_cnt);
      if (deliver) begin
        chk("pc4", PC_4, m_pc + 32'd4);
        chk("do", DO, word);
      end
      if (redir) begin
        m_pc = tgt; m_held = 1'b0;
      end else if (deliver) begin
        m_pc = m_pc + 32'd4; m_held = 1'b0; m_cnt = m_cnt + 32'd1;
      end else if (!m_held && imem_ready && stall) begin
        m_held = 1'b1; m_held_word = imem_data;
      end
    end
    @(negedge reloj);
  endtask

  initial begin
    model_init();
    @(negedge reloj);
    do_reset();

    // Straight-line fetch: boot, then 0,4,8,12 delivered, PC lands on 0x10.
    set_in(0, 1, 0, 0, 0, 0, 0);
    repeat (C_BOOT + 4) begin
      imem_data = $urandom;
      step();
    end
    chk("seq_addr", imem_addr, 32'h10);

    // Stall at 0x10: capture, hold three cycles, release.
    repeat (3) begin set_in(1, 1, 0, 0, 0, 0, 0); step(); end
    set_in(0, 0, 0, 0, 0, 0, 0); step();
    chk("hold_rel_addr", imem_addr, 32'h14);

    // Branch while held and stalled: held word dropped.
    set_in(1, 1, 0, 0, 0, 0, 0); step();
    set_in(1, 1, 0, 0, 0, 0, 0); step();
    set_in(1, 1, 1, 32'h100, 0, 0, 0); step();
    chk("br_hold_addr", imem_addr, 32'h100);

    // Branch beats jump; then jump alone.
    set_in(0, 1, 1, 32'h200, 1, 26'h40, 32'h4000_0008); step();
    chk("br_prio", imem_addr, 32'h200);
    set_in(0, 1, 0, 32'h200, 1, 26'h40, 32'h4000_0008); step();
    chk("jmp_tgt", imem_addr, 32'h4000_0100);

    // Stalled jump is ignored; word is held instead.
    set_in(1, 1, 0, 0, 1, 26'h3, 32'h0); step();
    set_in(0, 1, 0, 0, 0, 0, 0); step();

    // PC wrap at the top of the address space.
    set_in(0, 1, 1, 32'hFFFF_FFFC, 0, 0, 0); step();
    set_in(0, 1, 0, 0, 0, 0, 0); step();
    chk("wrap_addr", imem_addr, 32'h0);

    // Misaligned branch target loads as-is.
    set_in(0, 1, 1, 32'h0000_0103, 0, 0, 0); step();
    chk("misalign", imem_addr, 32'h103);

    // Async reset in the middle of a HOLD.
    set_in(1, 1, 0, 0, 0, 0, 0); step();
    set_in(1, 1, 0, 0, 0, 0, 0); step();
    do_reset();
    set_in(0, 1, 0, 0, 0, 0, 0);
    repeat (C_BOOT + 1) begin imem_data = $urandom; step(); end

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        set_in($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 70,
               $urandom_range(0, 99) < 8, $urandom,
               $urandom_range(0, 99) < 10, 26'($urandom), $urandom);
        step();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: PC loaded on reset.
REQ-002 SHALL have parameter BOOT_CYCLES, default 1: idle cycles after reset release before first request (range 1..15).
REQ-003 SHALL have one clock, reloj; reset is asynchronous and active-high, reset.
REQ-004 Ports (name  direction  width  meaning):
  reloj  in  1  clock, rising edge
  reset  in  1  async active-high reset
  stall  in  1  hazard unit holds IF/ID
  branch_taken  in  1  EX-stage branch resolved taken
  branch_target  in  32  EX-stage branch target
  jump  in  1  ID-stage J-type decoded
  jump_addr  in  26  ID-stage instruction bits [25:0]
  id_pc4  in  32  PC+4 currently held in IF/ID
  imem_req  out  1  fetch request
  imem_addr  out  32  fetch address
  imem_ready  in  1  imem_data valid this cycle
  imem_data  in  32  fetched instruction
  PC_4  out  32  PC+4 of delivered instruction
  DO  out  32  delivered instruction word
  enableIF  out  1  IF/ID load strobe
  resetIF  out  1  IF/ID flush
  fetch_count  out  32  instructions delivered since reset

Function
REQ-005 SHALL hold a 32-bit PC; imem_addr = PC at all times; PC+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0).
REQ-006 SHALL implement FSM states BOOT, FETCH, HOLD.
REQ-007 BOOT: imem_req=0, enableIF=0; internal counter runs BOOT_CYCLES cycles, then -> FETCH.
REQ-008 FETCH: imem_req=1; imem_ready=0 -> stay, PC unchanged.
REQ-009 FETCH, imem_ready=1, stall=0, no redirect: enableIF=1, PC_4=PC+4, DO=imem_data same cycle; PC<=PC+4; stay FETCH.
REQ-010 FETCH, imem_ready=1, stall=1, no redirect: capture {PC+4, imem_data} into hold buffer; enableIF=0; PC unchanged; -> HOLD.
REQ-011 HOLD: imem_req=0; while stall=1 enableIF=0; first cycle stall=0: enableIF=1, PC_4/DO from hold buffer, PC<=PC+4, -> FETCH.
REQ-012 Redirect target priority: branch_taken > jump > sequential.
REQ-013 Jump target SHALL be {id_pc4[31:28], jump_addr, 2'b00}.
REQ-014 branch_taken=1 (any state except BOOT, regardless of stall): PC<=branch_target, resetIF=1, enableIF=0, any imem_data or hold buffer discarded, -> FETCH.
REQ-015 jump=1 with stall=0 and branch_taken=0 (FETCH or HOLD): PC<=jump target, resetIF=1, enableIF=0, in-flight/held word discarded, -> FETCH; jump=1 with stall=1 ignored.
REQ-016 branch_taken/jump in BOOT SHALL be ignored.
REQ-017 resetIF = reset OR redirect (combinational); enableIF and resetIF never both 1.
REQ-018 fetch_count SHALL increment by 1 on each cycle enableIF=1, wrapping at 2^32; unchanged otherwise.
REQ-019 PC_4/DO SHALL be 32'h0 when enableIF=0 in BOOT; otherwise don't-care when enableIF=0.
REQ-020 Misaligned branch_target (bits[1:0]!=0) SHALL be loaded unchanged; no alignment correction.

Reset
REQ-021 reset=1 SHALL asynchronously set PC=RESET_PC, state=BOOT, boot counter=0, hold buffer=0, fetch_count=0.
REQ-022 During reset: imem_req=0, enableIF=0, resetIF=1.
REQ-023 Reset asserted mid-HOLD or mid-FETCH SHALL discard held/in-flight word; first request after release is to RESET_PC.

Verification
REQ-024 Reset release, imem_ready tied 1, stall=0 -> after BOOT_CYCLES, imem_addr 0,4,8,...; PC_4 4,8,12,...; fetch_count increments every cycle.
REQ-025 imem_ready=1 with stall=1 for 3 cycles at PC=0x10 -> HOLD, imem_req=0, enableIF=0 for 3 cycles; stall drop -> DO=held word, PC_4=0x14, next addr 0x14.
REQ-026 branch_taken=1, branch_target=0x100 while stall=1 in HOLD -> resetIF=1, enableIF=0 that cycle; next imem_addr=0x100; held word never delivered.
REQ-027 jump=1, branch_taken=1 same cycle, id_pc4=0x4000_0008, jump_addr=0x40, branch_target=0x200 -> next PC=0x200; repeat with branch_taken=0 -> next PC=0x4000_0100.
REQ-028 PC=0xFFFF_FFFC, imem_ready=1, stall=0 -> PC_4=0x0, next imem_addr=0x0.
REQ-029 Reset asserted asynchronously mid-cycle in HOLD -> outputs/state reset immediately (before next edge); after release first imem_addr=RESET_PC, fetch_count=0.
